// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - req/ack memory bus between the MEM stage and image/data memory
interface mem_access_stage_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: word/byte load/store over req/ack, one result per instruction
// Optional access timeout with sticky error flag: define MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_In,
    input  logic                MEM_RD_In,
    input  logic                MEM_WR_In,
    input  logic                BYTE_In,
    input  logic [31:0]         ALU_Result_In,
    input  logic [31:0]         St_Data_In,
    input  logic [3:0]          Rg_In,
    input  logic                WE_C_In,
    input  logic                WE_V_In,
    input  logic                SEL_C_In,
    input  logic                SEL_DAT_In,
    input  logic                SEL_STO_In,
    mem_access_stage_if.master  mem,
    output logic                stall_out,
    output logic [31:0]         Do_Out,
    output logic [7:0]          Dob_Out,
    output logic [31:0]         ALU_Result_Out,
    output logic [3:0]          Rg_Out,
    output logic                WE_C_Out,
    output logic                WE_V_Out,
    output logic                SEL_C_Out,
    output logic                SEL_DAT_Out,
    output logic                SEL_STO_Out,
    output logic                mem_err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic        pend;
    logic [31:0] l_alu;
    logic [3:0]  l_rg;
    logic        l_we_c, l_we_v, l_sel_c, l_sel_dat, l_sel_sto;
    logic        l_load;
    logic [1:0]  l_lane;

    logic emit_now;
    logic accept;
    logic is_mem;

    assign stall_out = (state == S_WAIT) && !mem.mem_ack;
    // A held result (memory completion or a queued ALU op) leaves at this edge.
    assign emit_now  = ((state == S_IDLE) && pend) || ((state == S_WAIT) && mem.mem_ack);
    assign accept    = valid_In && ((state == S_IDLE) || mem.mem_ack);
    assign is_mem    = MEM_RD_In || MEM_WR_In;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pend           <= 1'b0;
            l_alu          <= '0;
            l_rg           <= '0;
            l_we_c         <= 1'b0;
            l_we_v         <= 1'b0;
            l_sel_c        <= 1'b0;
            l_sel_dat      <= 1'b0;
            l_sel_sto      <= 1'b0;
            l_load         <= 1'b0;
            l_lane         <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_be     <= '0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            Do_Out         <= '0;
            Dob_Out        <= '0;
            ALU_Result_Out <= '0;
            Rg_Out         <= '0;
            WE_C_Out       <= 1'b0;
            WE_V_Out       <= 1'b0;
            SEL_C_Out      <= 1'b0;
            SEL_DAT_Out    <= 1'b0;
            SEL_STO_Out    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt            <= '0;
            mem_err        <= 1'b0;
`endif
        end else begin
            WE_C_Out <= 1'b0;
            WE_V_Out <= 1'b0;

            if (emit_now) begin
                ALU_Result_Out <= l_alu;
                Rg_Out         <= l_rg;
                WE_C_Out       <= l_we_c;
                WE_V_Out       <= l_we_v;
                SEL_C_Out      <= l_sel_c;
                SEL_DAT_Out    <= l_sel_dat;
                SEL_STO_Out    <= l_sel_sto;
                if ((state == S_WAIT) && l_load) begin
                    Do_Out  <= mem.mem_rdata;
                    Dob_Out <= mem.mem_rdata[{l_lane, 3'b000} +: 8];
                end else begin
                    Do_Out  <= '0;
                    Dob_Out <= '0;
                end
            end

            if (state == S_IDLE) begin
                pend <= 1'b0;
            end
            if ((state == S_WAIT) && mem.mem_ack) begin
                mem.mem_req <= 1'b0;
                state       <= S_IDLE;
            end

`ifdef MEM_TIMEOUT_EN
            if ((state == S_WAIT) && !mem.mem_ack) begin
                if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    mem.mem_req    <= 1'b0;
                    mem_err        <= 1'b1;
                    state          <= S_IDLE;
                    ALU_Result_Out <= l_alu;
                    Rg_Out         <= l_rg;
                    SEL_C_Out      <= l_sel_c;
                    SEL_DAT_Out    <= l_sel_dat;
                    SEL_STO_Out    <= l_sel_sto;
                    Do_Out         <= '0;
                    Dob_Out        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
`endif

            if (accept && (is_mem || emit_now)) begin
                l_alu     <= ALU_Result_In;
                l_rg      <= Rg_In;
                l_we_c    <= WE_C_In;
                l_we_v    <= WE_V_In;
                l_sel_c   <= SEL_C_In;
                l_sel_dat <= SEL_DAT_In;
                l_sel_sto <= SEL_STO_In;
                l_load    <= MEM_RD_In && !MEM_WR_In;
                l_lane    <= ALU_Result_In[1:0];
            end

            if (accept) begin
                if (is_mem) begin
                    state         <= S_WAIT;
                    pend          <= 1'b0;
                    mem.mem_req   <= 1'b1;
                    mem.mem_we    <= MEM_WR_In;
                    mem.mem_addr  <= ALU_Result_In[ADDR_W+1:2];
                    if (MEM_WR_In && BYTE_In) begin
                        mem.mem_be    <= 4'b0001 << ALU_Result_In[1:0];
                        mem.mem_wdata <= {4{St_Data_In[7:0]}};
                    end else begin
                        mem.mem_be    <= 4'hF;
                        mem.mem_wdata <= St_Data_In;
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt <= '0;
`endif
                end else if (emit_now) begin
                    // Output registers are taken by the held result; queue this ALU op one cycle.
                    pend <= 1'b1;
                end else begin
                    ALU_Result_Out <= ALU_Result_In;
                    Rg_Out         <= Rg_In;
                    WE_C_Out       <= WE_C_In;
                    WE_V_Out       <= WE_V_In;
                    SEL_C_Out      <= SEL_C_In;
                    SEL_DAT_Out    <= SEL_DAT_In;
                    SEL_STO_Out    <= SEL_STO_In;
                    Do_Out         <= '0;
                    Dob_Out        <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_In, MEM_RD_In, MEM_WR_In, BYTE_In;
    logic [31:0] ALU_Result_In, St_Data_In;
    logic [3:0]  Rg_In;
    logic        WE_C_In, WE_V_In, SEL_C_In, SEL_DAT_In, SEL_STO_In;
    logic        stall_out;
    logic [31:0] Do_Out, ALU_Result_Out;
    logic [7:0]  Dob_Out;
    logic [3:0]  Rg_Out;
    logic        WE_C_Out, WE_V_Out, SEL_C_Out, SEL_DAT_Out, SEL_STO_Out, mem_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage_if #(.ADDR_W(16)) mem_bus ();

    mem_access_stage #(.ADDR_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_In(valid_In), .MEM_RD_In(MEM_RD_In),
        .MEM_WR_In(MEM_WR_In), .BYTE_In(BYTE_In), .ALU_Result_In(ALU_Result_In),
        .St_Data_In(St_Data_In), .Rg_In(Rg_In), .WE_C_In(WE_C_In), .WE_V_In(WE_V_In),
        .SEL_C_In(SEL_C_In), .SEL_DAT_In(SEL_DAT_In), .SEL_STO_In(SEL_STO_In),
        .mem(mem_bus), .stall_out(stall_out), .Do_Out(Do_Out), .Dob_Out(Dob_Out),
        .ALU_Result_Out(ALU_Result_Out), .Rg_Out(Rg_Out), .WE_C_Out(WE_C_Out),
        .WE_V_Out(WE_V_Out), .SEL_C_Out(SEL_C_Out), .SEL_DAT_Out(SEL_DAT_Out),
        .SEL_STO_Out(SEL_STO_Out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic by,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] rg,
                         input logic wec, input logic wev);
        valid_In = v; MEM_RD_In = rd; MEM_WR_In = wr; BYTE_In = by;
        ALU_Result_In = alu; St_Data_In = st; Rg_In = rg;
        WE_C_In = wec; WE_V_In = wev; SEL_C_In = 1'b0; SEL_DAT_In = 1'b0; SEL_STO_In = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        tick; tick;
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_bus.mem_req); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_out); end
        checks++; if ({Do_Out, ALU_Result_Out, Dob_Out, Rg_Out} !== 76'd0) begin errors++; $display("FAIL reset_data got %h %h exp 0", Do_Out, ALU_Result_Out); end
        checks++; if ({WE_C_Out, WE_V_Out, mem_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {WE_C_Out, WE_V_Out, mem_err}); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_alu_only;
        drive(1, 0, 0, 0, 32'h1234, 0, 4'd5, 1, 0);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall_out); end
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (ALU_Result_Out !== 32'h1234) begin errors++; $display("FAIL alu_result got %h exp 00001234", ALU_Result_Out); end
        checks++; if ({WE_C_Out, WE_V_Out, Rg_Out} !== {2'b10, 4'd5}) begin errors++; $display("FAIL alu_ctrl got %b exp 100101", {WE_C_Out, WE_V_Out, Rg_Out}); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL alu_req got %b exp 0", mem_bus.mem_req); end
        tick;
        checks++; if (WE_C_Out !== 1'b0) begin errors++; $display("FAIL alu_we_pulse got %b exp 0", WE_C_Out); end
        checks++; if (ALU_Result_Out !== 32'h1234) begin errors++; $display("FAIL alu_hold got %h exp 00001234", ALU_Result_Out); end
    endtask

    task automatic test_word_load;
        drive(1, 1, 0, 0, 32'h40, 0, 4'd3, 0, 1);
        tick;
        checks++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be} !== 6'b10_1111) begin errors++; $display("FAIL wl_bus got %b exp 101111", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be}); end
        checks++; if (mem_bus.mem_addr !== 16'h10) begin errors++; $display("FAIL wl_addr got %h exp 0010", mem_bus.mem_addr); end
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL wl_stall1 got %b exp 1", stall_out); end
        tick;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL wl_stall2 got %b exp 1", stall_out); end
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hAABBCCDD;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL wl_stall_ack got %b exp 0", stall_out); end
        tick;
        mem_bus.mem_ack = 1'b0;
        checks++; if (Do_Out !== 32'hAABBCCDD) begin errors++; $display("FAIL wl_do got %h exp aabbccdd", Do_Out); end
        checks++; if (Dob_Out !== 8'hDD) begin errors++; $display("FAIL wl_dob got %h exp dd", Dob_Out); end
        checks++; if ({WE_C_Out, WE_V_Out, Rg_Out, mem_bus.mem_req} !== 7'b01_0011_0) begin errors++; $display("FAIL wl_ctrl got %b exp 0100110", {WE_C_Out, WE_V_Out, Rg_Out, mem_bus.mem_req}); end
        // Ack presented while idle must not produce anything.
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BADF00D;
        tick;
        mem_bus.mem_ack = 1'b0;
        checks++; if ({WE_V_Out, mem_bus.mem_req} !== 2'b00 || Do_Out !== 32'hAABBCCDD) begin errors++; $display("FAIL idle_ack got %b %h exp 00 aabbccdd", {WE_V_Out, mem_bus.mem_req}, Do_Out); end
    endtask

    task automatic test_byte_load;
        drive(1, 1, 0, 1, 32'h43, 0, 4'd2, 1, 0);
        tick;
        checks++; if ({mem_bus.mem_be, mem_bus.mem_addr} !== {4'hF, 16'h10}) begin errors++; $display("FAIL bl_bus got %h %h exp f 0010", mem_bus.mem_be, mem_bus.mem_addr); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h11223344;
        tick;
        mem_bus.mem_ack = 1'b0;
        checks++; if (Dob_Out !== 8'h11) begin errors++; $display("FAIL bl_dob got %h exp 11", Dob_Out); end
        checks++; if ({Do_Out, WE_C_Out} !== {32'h11223344, 1'b1}) begin errors++; $display("FAIL bl_do got %h %b exp 11223344 1", Do_Out, WE_C_Out); end
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 1, 1, 32'h42, 32'h5A, 4'd9, 1, 0);
        tick;
        checks++; if ({mem_bus.mem_we, mem_bus.mem_be} !== 5'b1_0100) begin errors++; $display("FAIL bs_be got %b exp 10100", {mem_bus.mem_we, mem_bus.mem_be}); end
        checks++; if (mem_bus.mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL bs_wdata got %h exp 5a5a5a5a", mem_bus.mem_wdata); end
        drive(1, 1, 0, 0, 32'h80, 0, 4'd7, 1, 1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h99999999;
        tick;
        mem_bus.mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({Rg_Out, WE_C_Out, Do_Out, ALU_Result_Out} !== {4'd9, 1'b1, 32'h0, 32'h42}) begin errors++; $display("FAIL bs_result got %h %b %h %h exp 9 1 0 42", Rg_Out, WE_C_Out, Do_Out, ALU_Result_Out); end
        checks++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr} !== {2'b10, 16'h20}) begin errors++; $display("FAIL b2b_req got %b %b %h exp 1 0 0020", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr); end
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
        tick;
        mem_bus.mem_ack = 1'b0;
        checks++; if ({Do_Out, Rg_Out, ALU_Result_Out} !== {32'hCAFEF00D, 4'd7, 32'h80}) begin errors++; $display("FAIL b2b_load got %h %h %h exp cafef00d 7 80", Do_Out, Rg_Out, ALU_Result_Out); end
    endtask

    task automatic test_rd_wr_both;
        drive(1, 1, 1, 0, 32'h13, 32'h12345678, 4'd1, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr} !== {1'b1, 4'hF, 32'h12345678, 16'h4}) begin errors++; $display("FAIL rw_bus got %b %h %h %h exp 1 f 12345678 0004", mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr); end
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFFFFFF;
        tick;
        mem_bus.mem_ack = 1'b0;
        checks++; if ({Do_Out, Dob_Out, WE_V_Out} !== {32'h0, 8'h0, 1'b1}) begin errors++; $display("FAIL rw_data got %h %h %b exp 0 0 1", Do_Out, Dob_Out, WE_V_Out); end
    endtask

    task automatic test_alu_after_mem;
        drive(1, 1, 0, 0, 32'h20, 0, 4'd6, 0, 1);
        tick;
        drive(1, 0, 0, 0, 32'h777, 0, 4'd4, 1, 0);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h01020304;
        tick;
        mem_bus.mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({Do_Out, Rg_Out, WE_V_Out} !== {32'h01020304, 4'd6, 1'b1}) begin errors++; $display("FAIL am_load got %h %h %b exp 01020304 6 1", Do_Out, Rg_Out, WE_V_Out); end
        tick;
        checks++; if ({ALU_Result_Out, Rg_Out, WE_C_Out, WE_V_Out, Do_Out} !== {32'h777, 4'd4, 2'b10, 32'h0}) begin errors++; $display("FAIL am_alu got %h %h %b %b %h exp 777 4 1 0 0", ALU_Result_Out, Rg_Out, WE_C_Out, WE_V_Out, Do_Out); end
        tick;
        checks++; if (WE_C_Out !== 1'b0) begin errors++; $display("FAIL am_single got %b exp 0", WE_C_Out); end
    endtask

    task automatic test_reset_mid;
        drive(1, 1, 0, 0, 32'h44, 0, 4'd8, 1, 1);
        tick;
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_pre got %b exp 1", mem_bus.mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_bus.mem_req, stall_out} !== 2'b00) begin errors++; $display("FAIL rm_req got %b exp 00", {mem_bus.mem_req, stall_out}); end
        checks++; if ({Do_Out, ALU_Result_Out, Rg_Out} !== 68'd0) begin errors++; $display("FAIL rm_data got %h %h exp 0", Do_Out, ALU_Result_Out); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        tick;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h55555555;
        tick;
        mem_bus.mem_ack = 1'b0;
        tick;
        checks++; if ({WE_C_Out, WE_V_Out, mem_bus.mem_req, Do_Out} !== 35'd0) begin errors++; $display("FAIL rm_late_ack got %b %h exp 0", {WE_C_Out, WE_V_Out, mem_bus.mem_req}, Do_Out); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        drive(1, 1, 0, 0, 32'h60, 0, 4'd2, 1, 1);
        tick;
        tick; tick; tick;
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL to_req3 got %b exp 1", mem_bus.mem_req); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        checks++; if ({mem_bus.mem_req, mem_err, WE_C_Out, WE_V_Out} !== 4'b0100) begin errors++; $display("FAIL to_drop got %b exp 0100", {mem_bus.mem_req, mem_err, WE_C_Out, WE_V_Out}); end
        tick; tick;
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_err); end
    endtask
`endif

    initial begin
        test_reset;
        test_alu_only;
        test_word_load;
        test_byte_load;
        test_back_to_back;
        test_rd_wr_both;
        test_alu_after_mem;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`else
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_tied got %b exp 0", mem_err); end
`endif
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
